// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the GPU memory path (L1 and miss handling).
package gpu_mem_pkg;

    localparam int unsigned GPU_ADDR_W = 32;
    localparam int unsigned GPU_DATA_W = 64;
    localparam int unsigned GPU_WARP_W = 6;

    typedef enum logic [1:0] {
        MSHR_FREE   = 2'd0,
        MSHR_PEND   = 2'd1,
        MSHR_ISSUED = 2'd2,
        MSHR_DONE   = 2'd3
    } mshr_state_t;

    // Control part of an MSHR entry; the width-parameterised payload lives beside it.
    typedef struct packed {
        mshr_state_t state;
        logic        write;
    } mshr_entry_t;

endpackage

// File: rtl/gpu_prio_enc.sv
// Lowest-index set-bit encoder with a valid flag.
module gpu_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_miss_handler.sv
// L1 miss handler: MSHR tracking, global-memory request issue and out-of-order fill return.
// Optional build macro GPU_MISS_PERF_EN adds miss and stall performance counters.
module gpu_miss_handler
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_MSHR = 4,
    parameter int unsigned ADDR_W   = GPU_ADDR_W,
    parameter int unsigned DATA_W   = GPU_DATA_W,
    parameter int unsigned WARP_W   = GPU_WARP_W,
    localparam int unsigned ID_W    = $clog2(NUM_MSHR)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WARP_W-1:0] miss_warp,
    input  logic              miss_write,
    input  logic [DATA_W-1:0] miss_wdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_write,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [ID_W-1:0]   mem_req_id,

    input  logic              mem_rsp_valid,
    input  logic [ID_W-1:0]   mem_rsp_id,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [WARP_W-1:0] fill_warp,
    output logic [DATA_W-1:0] fill_data,

    output logic              busy
`ifdef GPU_MISS_PERF_EN
    ,
    output logic [31:0]       perf_miss_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    mshr_entry_t       ent      [NUM_MSHR];
    logic [ADDR_W-1:0] ent_addr [NUM_MSHR];
    logic [WARP_W-1:0] ent_warp [NUM_MSHR];
    logic [DATA_W-1:0] ent_data [NUM_MSHR];

    logic [ID_W-1:0]     fill_id;
    logic [NUM_MSHR-1:0] free_vec, pend_vec, done_vec;
    logic [ID_W-1:0]     free_idx, pend_idx, done_idx;
    logic                free_any, pend_any, done_any;

    logic              alloc, req_load, rsp_hit, fill_free, fill_from_done, fill_from_rsp;
    logic [DATA_W-1:0] rsp_fill_data;

    // The entry already held in the fill register stays DONE but must not be selected again.
    always_comb begin
        free_vec = '0;
        pend_vec = '0;
        done_vec = '0;
        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            free_vec[i] = (ent[i].state == MSHR_FREE);
            pend_vec[i] = (ent[i].state == MSHR_PEND);
            done_vec[i] = (ent[i].state == MSHR_DONE) &&
                          !(fill_valid && (fill_id == ID_W'(i)));
        end
    end

    gpu_prio_enc #(.N(NUM_MSHR), .W(ID_W)) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .valid (free_any)
    );

    gpu_prio_enc #(.N(NUM_MSHR), .W(ID_W)) u_pend_sel (
        .req   (pend_vec),
        .idx   (pend_idx),
        .valid (pend_any)
    );

    gpu_prio_enc #(.N(NUM_MSHR), .W(ID_W)) u_done_sel (
        .req   (done_vec),
        .idx   (done_idx),
        .valid (done_any)
    );

    assign miss_ready = free_any;
    assign busy       = ~(&free_vec);

    // A response can bypass straight into an idle fill register to reach one-cycle latency.
    always_comb begin
        alloc          = miss_valid && free_any;
        req_load       = pend_any && (!mem_req_valid || mem_req_ready);
        rsp_hit        = mem_rsp_valid && (ent[mem_rsp_id].state == MSHR_ISSUED);
        fill_free      = !fill_valid || fill_ready;
        fill_from_done = fill_free && done_any;
        fill_from_rsp  = fill_free && !done_any && rsp_hit;
        rsp_fill_data  = ent[mem_rsp_id].write ? ent_data[mem_rsp_id] : mem_rsp_data;
    end

    // Entry state transitions; every event in one cycle targets a distinct entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_MSHR); i++) begin
                ent[i] <= '{state: MSHR_FREE, write: 1'b0};
            end
        end else begin
            if (fill_valid && fill_ready) begin
                ent[fill_id].state <= MSHR_FREE;
            end
            if (alloc) begin
                ent[free_idx] <= '{state: MSHR_PEND, write: miss_write};
            end
            if (req_load) begin
                ent[pend_idx].state <= MSHR_ISSUED;
            end
            if (rsp_hit) begin
                ent[mem_rsp_id].state <= MSHR_DONE;
            end
        end
    end

    // Payload storage; write misses keep their wdata as the eventual fill data.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[free_idx] <= miss_addr;
            ent_warp[free_idx] <= miss_warp;
            ent_data[free_idx] <= miss_wdata;
        end
        if (rsp_hit && !ent[mem_rsp_id].write) begin
            ent_data[mem_rsp_id] <= mem_rsp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_write <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_id    <= '0;
        end else if (req_load) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= ent_addr[pend_idx];
            mem_req_write <= ent[pend_idx].write;
            mem_req_wdata <= ent_data[pend_idx];
            mem_req_id    <= pend_idx;
        end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_warp  <= '0;
            fill_data  <= '0;
            fill_id    <= '0;
        end else if (fill_from_done) begin
            fill_valid <= 1'b1;
            fill_addr  <= ent_addr[done_idx];
            fill_warp  <= ent_warp[done_idx];
            fill_data  <= ent_data[done_idx];
            fill_id    <= done_idx;
        end else if (fill_from_rsp) begin
            fill_valid <= 1'b1;
            fill_addr  <= ent_addr[mem_rsp_id];
            fill_warp  <= ent_warp[mem_rsp_id];
            fill_data  <= rsp_fill_data;
            fill_id    <= mem_rsp_id;
        end else if (fill_ready) begin
            fill_valid <= 1'b0;
        end
    end

`ifdef GPU_MISS_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_miss_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (alloc) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
            if (miss_valid && !free_any) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpu_miss_handler.sv
// Directed self-checking bench for gpu_miss_handler (4 MSHRs, default widths).
module tb_gpu_miss_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_addr = '0;
    logic [5:0]  miss_warp = '0;
    logic        miss_write = 1'b0;
    logic [63:0] miss_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_req_write;
    logic [63:0] mem_req_wdata;
    logic [1:0]  mem_req_id;
    logic        mem_rsp_valid = 1'b0;
    logic [1:0]  mem_rsp_id = '0;
    logic [63:0] mem_rsp_data = '0;
    logic        fill_valid;
    logic        fill_ready = 1'b1;
    logic [31:0] fill_addr;
    logic [5:0]  fill_warp;
    logic [63:0] fill_data;
    logic        busy;
`ifdef GPU_MISS_PERF_EN
    logic [31:0] perf_miss_cnt, perf_stall_cnt;
`endif

    gpu_miss_handler dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .miss_warp     (miss_warp),
        .miss_write    (miss_write),
        .miss_wdata    (miss_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_write (mem_req_write),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_id    (mem_req_id),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_id    (mem_rsp_id),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_addr     (fill_addr),
        .fill_warp     (fill_warp),
        .fill_data     (fill_data),
        .busy          (busy)
`ifdef GPU_MISS_PERF_EN
        ,
        .perf_miss_cnt (perf_miss_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [63:0] data;
        logic [1:0]  id;
        logic [5:0]  warp;
    } txn_t;

    txn_t req_q[$];
    txn_t fill_q[$];
    int   checks = 0;
    int   failures = 0;

    // Handshakes are recorded mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req_valid && mem_req_ready)
                req_q.push_back('{mem_req_addr, mem_req_write, mem_req_wdata, mem_req_id, 6'd0});
            if (fill_valid && fill_ready)
                fill_q.push_back('{fill_addr, 1'b0, fill_data, 2'd0, fill_warp});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_miss(input logic [31:0] a, input logic [5:0] w,
                             input logic wr, input logic [63:0] d);
        int c = 0;
        miss_valid = 1'b1; miss_addr = a; miss_warp = w; miss_write = wr; miss_wdata = d;
        while (!miss_ready && c < 100) begin
            tick();
            c++;
        end
        if (!miss_ready) check("miss_accept_timeout", 64'(miss_ready), 64'd1);
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [1:0] id, input logic [63:0] d);
        mem_rsp_valid = 1'b1; mem_rsp_id = id; mem_rsp_data = d;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input string tag);
        for (int c = 0; c < 50 && req_q.size() < n; c++) tick();
        check(tag, 64'(req_q.size()), 64'(n));
    endtask

    task automatic wait_fills(input int n, input string tag);
        for (int c = 0; c < 50 && fill_q.size() < n; c++) tick();
        check(tag, 64'(fill_q.size()), 64'(n));
    endtask

    initial begin
        logic [63:0] dv [4];
        logic [31:0] ha;
        logic [63:0] hd;
        logic [1:0]  hi;
        logic        hw, ok;
        int          nreq, nfill, c;
        int          order [4];

        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_miss_ready", 64'(miss_ready), 64'd1);
        check("rst_fill_data", fill_data, 64'd0);
        check("rst_req_addr", 64'(mem_req_addr), 64'd0);

        // Single read miss with a 5-cycle memory latency
        send_miss(32'h100, 6'd3, 1'b0, 64'd0);
        check("rd_req_not_yet", 64'(mem_req_valid), 64'd0);
        tick();
        check("rd_req_n2", 64'(mem_req_valid), 64'd1);
        wait_reqs(1, "rd_req_count");
        check("rd_req_addr", 64'(req_q[0].addr), 64'h100);
        check("rd_req_write", 64'(req_q[0].write), 64'd0);
        check("rd_req_id", 64'(req_q[0].id), 64'd0);
        repeat (5) tick();
        send_rsp(2'd0, 64'hDEADBEEF_CAFEF00D);
        check("rd_fill_lat1", 64'(fill_valid), 64'd1);
        wait_fills(1, "rd_fill_count");
        check("rd_fill_addr", 64'(fill_q[0].addr), 64'h100);
        check("rd_fill_warp", 64'(fill_q[0].warp), 64'd3);
        check("rd_fill_data", fill_q[0].data, 64'hDEADBEEF_CAFEF00D);
        check("rd_busy_idle", 64'(busy), 64'd0);

        // Write miss: fill data is the stored write data, not the ack payload
        send_miss(32'h200, 6'd5, 1'b1, 64'h1234);
        wait_reqs(2, "wr_req_count");
        check("wr_req_write", 64'(req_q[1].write), 64'd1);
        check("wr_req_wdata", req_q[1].data, 64'h1234);
        check("wr_req_addr", 64'(req_q[1].addr), 64'h200);
        send_rsp(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_fills(2, "wr_fill_count");
        check("wr_fill_data", fill_q[1].data, 64'h1234);
        check("wr_fill_addr", 64'(fill_q[1].addr), 64'h200);

        // Fill all four entries, stall a fifth, respond out of order 2,0,3,1
        fill_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dv[i] = 64'h1111_0000_0000_0000 + 64'(i) * 64'h10001;
            send_miss(32'h1000 + 32'(i) * 32'h40, 6'(8 + i), 1'b0, 64'd0);
        end
        miss_valid = 1'b1; miss_addr = 32'h2000; miss_warp = 6'd20;
        miss_write = 1'b0; miss_wdata = 64'd0;
        check("full_miss_ready", 64'(miss_ready), 64'd0);
        wait_reqs(6, "full_req_count");
        for (int i = 0; i < 4; i++) check("full_req_id", 64'(req_q[2 + i].id), 64'(i));
        send_rsp(2'd2, dv[2]);
        send_rsp(2'd0, dv[0]);
        send_rsp(2'd3, dv[3]);
        send_rsp(2'd1, dv[1]);
        check("ooo_first_fill", fill_data, dv[2]);
        check("ooo_still_full", 64'(miss_ready), 64'd0);
        fill_ready = 1'b1;
        check("free_not_same_cycle", 64'(miss_ready), 64'd0);
        tick();
        check("free_next_cycle", 64'(miss_ready), 64'd1);
        tick();
        miss_valid = 1'b0;
        wait_fills(6, "ooo_fill_count");
        order = '{2, 0, 1, 3};
        for (int i = 0; i < 4; i++) begin
            check("ooo_fill_addr", 64'(fill_q[2 + i].addr), 64'(32'h1000 + 32'(order[i]) * 32'h40));
            check("ooo_fill_warp", 64'(fill_q[2 + i].warp), 64'(8 + order[i]));
            check("ooo_fill_data", fill_q[2 + i].data, dv[order[i]]);
        end
        wait_reqs(7, "fifth_req_count");
        check("fifth_req_id", 64'(req_q[6].id), 64'd2);
        check("fifth_req_addr", 64'(req_q[6].addr), 64'h2000);
        send_rsp(2'd2, 64'h5555);
        wait_fills(7, "fifth_fill_count");
        check("fifth_fill_warp", 64'(fill_q[6].warp), 64'd20);
        check("fifth_fill_data", fill_q[6].data, 64'h5555);

        // Backpressure on both the request and the fill side
        mem_req_ready = 1'b0;
        nreq = req_q.size();
        nfill = fill_q.size();
        send_miss(32'h300, 6'd7, 1'b1, 64'h55AA);
        c = 0;
        while (!mem_req_valid && c < 20) begin tick(); c++; end
        check("bp_req_valid", 64'(mem_req_valid), 64'd1);
        ha = mem_req_addr; hd = mem_req_wdata; hi = mem_req_id; hw = mem_req_write;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ok &= mem_req_valid && mem_req_addr == ha && mem_req_wdata == hd &&
                  mem_req_id == hi && mem_req_write == hw;
        end
        check("bp_req_hold", 64'(ok), 64'd1);
        check("bp_req_addr", 64'(ha), 64'h300);
        mem_req_ready = 1'b1;
        wait_reqs(nreq + 1, "bp_req_count");
        fill_ready = 1'b0;
        send_rsp(hi, 64'hAAAA);
        check("bp_fill_valid", 64'(fill_valid), 64'd1);
        ha = fill_addr; hd = fill_data;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ok &= fill_valid && fill_addr == ha && fill_data == hd && fill_warp == 6'd7;
        end
        check("bp_fill_hold", 64'(ok), 64'd1);
        fill_ready = 1'b1;
        wait_fills(nfill + 1, "bp_fill_count");
        check("bp_fill_data", fill_q[nfill].data, 64'h55AA);
        repeat (3) tick();
        check("bp_no_dup_req", 64'(req_q.size()), 64'(nreq + 1));
        check("bp_no_dup_fill", 64'(fill_q.size()), 64'(nfill + 1));

        // Reset with two entries issued, then a late response
        send_miss(32'h400, 6'd1, 1'b0, 64'd0);
        send_miss(32'h440, 6'd2, 1'b0, 64'd0);
        wait_reqs(nreq + 3, "rst_mid_reqs");
        nfill = fill_q.size();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rstm_busy", 64'(busy), 64'd0);
        check("rstm_miss_ready", 64'(miss_ready), 64'd1);
        check("rstm_req_valid", 64'(mem_req_valid), 64'd0);
        send_rsp(2'd1, 64'hBAD);
        tick();
        check("late_fill_valid", 64'(fill_valid), 64'd0);
        check("late_busy", 64'(busy), 64'd0);
        check("late_fill_count", 64'(fill_q.size()), 64'(nfill));
`ifdef GPU_MISS_PERF_EN
        check("perf_miss_after_rst", 64'(perf_miss_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
